// File: rtl/pwm_capture_pkg.sv
// Shared types and default sizing for the PWM capture block.
// Defaults match the generator's duty code width and a long stuck-line timeout.
package pwm_capture_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_CNT_W   = 24;
  localparam int DEFAULT_TIMEOUT = 8_000_000;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  // Divider handshake: abort has priority over start.
  typedef struct packed {
    logic start;
    logic abort;
  } div_req_t;

  typedef struct packed {
    logic busy;
    logic done;
  } div_rsp_t;

endpackage

// File: rtl/pwm_capture_div.sv
// Sequential restoring divider producing floor(dividend * 2^WIDTH / divisor),
// one quotient bit per cycle; the caller guarantees dividend < divisor.
module pwm_capture_div
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_i,
  input  div_req_t         req_i,
  input  logic [CNT_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output div_rsp_t         rsp_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int ITER_W = $clog2(WIDTH + 1);

  logic              busy_q, busy_d;
  logic [CNT_W:0]    rem_q, rem_d;
  logic [CNT_W-1:0]  divisor_q, divisor_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic [CNT_W:0]    rem_shift;
  logic [CNT_W:0]    rem_sub;
  logic              ge;
  logic              last_iter;
  logic [WIDTH-1:0]  quo_next;

  // Remainder stays below the divisor, so one extra bit holds the shifted value.
  assign rem_shift = rem_q << 1;
  assign rem_sub   = rem_shift - {1'b0, divisor_q};
  assign ge        = rem_shift >= {1'b0, divisor_q};
  assign last_iter = busy_q && (iter_q == ITER_W'(1));
  assign quo_next  = (quo_q << 1) | WIDTH'(ge);

  always_comb begin
    busy_d    = busy_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    iter_d    = iter_q;
    if (req_i.abort) begin
      busy_d = 1'b0;
    end else if (req_i.start && !busy_q) begin
      busy_d    = 1'b1;
      rem_d     = {1'b0, dividend_i};
      divisor_d = divisor_i;
      quo_d     = '0;
      iter_d    = ITER_W'(WIDTH);
    end else if (busy_q) begin
      rem_d  = ge ? rem_sub : rem_shift;
      quo_d  = quo_next;
      iter_d = iter_q - ITER_W'(1);
      if (last_iter) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      rem_q     <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      iter_q    <= '0;
    end else begin
      busy_q    <= busy_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      iter_q    <= iter_d;
    end
  end

  assign rsp_o.busy = busy_q;
  assign rsp_o.done = last_iter && !req_i.abort;
  assign quotient_o = quo_next;

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and duty code of an asynchronous PWM input.
// Define PWM_CAPTURE_DEGLITCH_EN to add a 3-sample stability filter after the synchronizer.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             ena,
  input  logic             pwm_i,
  output logic [WIDTH-1:0] duty_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             overrun_o
);

  logic [1:0]       sync_q, sync_d;
  logic             s, s_d_q, s_d_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d;
  logic [CNT_W-1:0] snap_per_q, snap_per_d, snap_hi_q, snap_hi_d;
  logic             stuck_rep_q, stuck_rep_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, stuck_q, stuck_d, overrun_q, overrun_d;

  logic             rise, fall, timeout;
  logic [CNT_W-1:0] per_inc, hi_inc;
  div_req_t         div_req;
  div_rsp_t         div_rsp;
  logic [WIDTH-1:0] quotient;

  assign sync_d = {sync_q[0], pwm_i};

`ifdef PWM_CAPTURE_DEGLITCH_EN
  logic [1:0] hist_q, hist_d;
  logic       filt_q, filt_d;

  // The filtered level follows only after three equal synchronized samples.
  assign hist_d = {hist_q[0], sync_q[1]};
  assign filt_d = (sync_q[1] == hist_q[0] && hist_q[0] == hist_q[1]) ? sync_q[1] : filt_q;
  assign s      = filt_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end
`else
  assign s = sync_q[1];
`endif

  assign s_d_d   = s;
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign per_inc = (per_q == '1) ? per_q : per_q + CNT_W'(1);
  assign hi_inc  = (hi_q == '1) ? hi_q : hi_q + CNT_W'(1);
  // A rise in the timeout cycle wins; a stuck line is reported only once per rise.
  assign timeout = (per_q == CNT_W'(TIMEOUT)) && !rise && !stuck_rep_q;

  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    hi_d        = hi_q;
    snap_per_d  = snap_per_q;
    snap_hi_d   = snap_hi_q;
    stuck_rep_d = stuck_rep_q;
    duty_d      = duty_q;
    period_d    = period_q;
    high_d      = high_q;
    stuck_d     = stuck_q;
    valid_d     = 1'b0;
    overrun_d   = 1'b0;
    div_req     = '0;
    if (!ena) begin
      state_d       = IDLE;
      per_d         = '0;
      hi_d          = '0;
      div_req.abort = 1'b1;
    end else begin
      if (rise) begin
        per_d       = CNT_W'(1);
        hi_d        = CNT_W'(1);
        stuck_rep_d = 1'b0;
      end else begin
        per_d = per_inc;
        if (s) hi_d = hi_inc;
      end
      case (state_q)
        IDLE: if (rise) state_d = HIGH;
        HIGH: if (fall) state_d = LOW;
        LOW: begin
          if (rise) begin
            state_d = HIGH;
            if (!div_rsp.busy) begin
              div_req.start = 1'b1;
              snap_per_d    = per_q;
              snap_hi_d     = hi_q;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (div_rsp.done) begin
        duty_d   = quotient;
        period_d = snap_per_q;
        high_d   = snap_hi_q;
        stuck_d  = 1'b0;
        valid_d  = 1'b1;
      end
      if (timeout) begin
        state_d     = IDLE;
        stuck_rep_d = 1'b1;
        duty_d      = {WIDTH{s}};
        period_d    = '0;
        high_d      = '0;
        stuck_d     = 1'b1;
        valid_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      s_d_q       <= 1'b0;
      state_q     <= IDLE;
      per_q       <= '0;
      hi_q        <= '0;
      snap_per_q  <= '0;
      snap_hi_q   <= '0;
      stuck_rep_q <= 1'b0;
      duty_q      <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      s_d_q       <= s_d_d;
      state_q     <= state_d;
      per_q       <= per_d;
      hi_q        <= hi_d;
      snap_per_q  <= snap_per_d;
      snap_hi_q   <= snap_hi_d;
      stuck_rep_q <= stuck_rep_d;
      duty_q      <= duty_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      overrun_q   <= overrun_d;
    end
  end

  pwm_capture_div #(
    .CNT_W(CNT_W),
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_i     (rst_i),
    .req_i     (div_req),
    .dividend_i(snap_hi_d),
    .divisor_i (snap_per_d),
    .rsp_o     (div_rsp),
    .quotient_o(quotient)
  );

  assign duty_o    = duty_q;
  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign stuck_o   = stuck_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed and random PWM bursts scored against an
// event-level model that predicts every report and overrun from edge times.
module tb_pwm_capture;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst_i, ena, pwm_i;
  logic [WIDTH-1:0] duty_o;
  logic [CNT_W-1:0] period_o, high_o;
  logic             valid_o, stuck_o, overrun_o;

  pwm_capture #(
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .ena      (ena),
    .pwm_i    (pwm_i),
    .duty_o   (duty_o),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .stuck_o  (stuck_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int duty;
    int per;
    int hi;
    int stuck;
  } report_t;

  report_t rep_q[$];
  int      ovr_q[$];
  report_t mon_r;
  int      checks = 0;
  int      failures = 0;

  bit meas_valid, have_start;
  int rise_t, fall_t, last_start;
  int last_duty, last_per, last_hi, last_stuck;

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A rise after a full period yields a report WIDTH+3 edges later, unless the
  // divider is still busy with a start fewer than WIDTH+1 cycles ago.
  function automatic void model_rise(input int t);
    int per, hi;
    report_t r;
    if (!ena) return;
    if (meas_valid) begin
      per = t - rise_t;
      hi  = fall_t - rise_t;
      if (!have_start || (t - last_start) >= WIDTH + 1) begin
        r.due   = t + WIDTH + 3;
        r.duty  = (hi * (1 << WIDTH)) / per;
        r.per   = per;
        r.hi    = hi;
        r.stuck = 0;
        rep_q.push_back(r);
        have_start = 1'b1;
        last_start = t;
      end else begin
        ovr_q.push_back(t + 3);
      end
    end
    meas_valid = 1'b1;
    rise_t     = t;
  endfunction

  function automatic void expect_timeout(input int due, input int duty);
    report_t r;
    r.due   = due;
    r.duty  = duty;
    r.per   = 0;
    r.hi    = 0;
    r.stuck = 1;
    rep_q.push_back(r);
    meas_valid = 1'b0;
  endfunction

  function automatic void model_reset();
    rep_q.delete();
    ovr_q.delete();
    meas_valid = 1'b0;
    have_start = 1'b0;
    last_duty  = 0;
    last_per   = 0;
    last_hi    = 0;
    last_stuck = 0;
  endfunction

  task automatic apply_stimulus(input bit lvl, input int n);
    if (lvl && !pwm_i) model_rise(cyc);
    if (!lvl && pwm_i) fall_t = cyc;
    pwm_i = lvl;
    repeat (n) step();
  endtask

  task automatic pwm_burst(input int h, input int l, input int reps);
    repeat (reps) begin
      apply_stimulus(1'b1, h);
      apply_stimulus(1'b0, l);
    end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_duty", duty_o, 0);
    check_output("rst_period", period_o, 0);
    check_output("rst_high", high_o, 0);
    check_output("rst_valid", valid_o, 0);
    check_output("rst_stuck", stuck_o, 0);
    check_output("rst_overrun", overrun_o, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      while (rep_q.size() > 0 && rep_q[0].due < cyc) begin
        check_output("late_valid", cyc, rep_q[0].due);
        void'(rep_q.pop_front());
      end
      if (rep_q.size() > 0 && rep_q[0].due == cyc) begin
        mon_r = rep_q.pop_front();
        check_output("valid", valid_o, 1);
        check_output("duty", duty_o, mon_r.duty);
        check_output("period", period_o, mon_r.per);
        check_output("high", high_o, mon_r.hi);
        check_output("stuck", stuck_o, mon_r.stuck);
        last_duty  = mon_r.duty;
        last_per   = mon_r.per;
        last_hi    = mon_r.hi;
        last_stuck = mon_r.stuck;
      end else if (valid_o) begin
        check_output("spurious_valid", valid_o, 0);
      end
      while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
        check_output("late_overrun", cyc, ovr_q[0]);
        void'(ovr_q.pop_front());
      end
      if (ovr_q.size() > 0 && ovr_q[0] == cyc) begin
        void'(ovr_q.pop_front());
        check_output("overrun", overrun_o, 1);
      end else if (overrun_o) begin
        check_output("spurious_overrun", overrun_o, 0);
      end
    end
  end

  initial begin
    int h, l, r;
    rst_i = 1'b1;
    ena   = 1'b1;
    pwm_i = 1'b0;
    fall_t = 0;
    rise_t = 0;
    last_start = 0;
    model_reset();
    repeat (3) step();
    check_reset_outputs();

    // Idle line after reset: one stuck-low report after TIMEOUT+1 cycles.
    rst_i = 1'b0;
    expect_timeout(cyc + 1 + TIMEOUT, 0);
    apply_stimulus(1'b0, 1100);
    check_output("idle_stuck_level", stuck_o, 1);

    // Nominal and fractional duty.
    pwm_burst(64, 192, 4);
    check_output("nominal_duty", duty_o, 64);
    check_output("nominal_period", period_o, 256);
    check_output("nominal_stuck", stuck_o, 0);
    pwm_burst(1, 99, 4);
    check_output("frac_duty", duty_o, 2);
    check_output("frac_period", period_o, 100);
    check_output("frac_high", high_o, 1);

    // Stuck high, then recovery.
    h = cyc;
    apply_stimulus(1'b1, 1);
    expect_timeout(h + 3 + TIMEOUT, 255);
    apply_stimulus(1'b1, 1099);
    check_output("stuck_hi_level", stuck_o, 1);
    check_output("stuck_hi_duty", duty_o, 255);
    apply_stimulus(1'b0, 30);
    pwm_burst(10, 30, 3);
    check_output("resume_stuck", stuck_o, 0);
    check_output("resume_duty", duty_o, 64);

    // Short periods overrun the divider on alternate periods.
    pwm_burst(2, 3, 8);
    apply_stimulus(1'b0, 20);
    check_output("ovr_duty", duty_o, 102);
    check_output("ovr_period", period_o, 5);

    // Random bursts.
    repeat (12) begin
      h = $urandom_range(40, 1);
      l = $urandom_range(40, 1);
      r = $urandom_range(4, 1);
      pwm_burst(h, l, r);
    end

    // Capture disabled: reports suppressed, outputs held, first report needs a full period.
    apply_stimulus(1'b0, 20);
    ena = 1'b0;
    while (rep_q.size() > 0 && rep_q[rep_q.size()-1].due > cyc) void'(rep_q.pop_back());
    while (ovr_q.size() > 0 && ovr_q[ovr_q.size()-1] > cyc) void'(ovr_q.pop_back());
    meas_valid = 1'b0;
    have_start = 1'b0;
    pwm_burst(5, 5, 3);
    apply_stimulus(1'b0, 20);
    check_output("hold_duty", duty_o, last_duty);
    check_output("hold_period", period_o, last_per);
    check_output("hold_high", high_o, last_hi);
    check_output("hold_stuck", stuck_o, last_stuck);
    ena = 1'b1;
    apply_stimulus(1'b0, 5);
    pwm_burst(20, 40, 3);
    check_output("reena_duty", duty_o, 85);

    // Reset while counting the high phase.
    apply_stimulus(1'b1, 10);
    rst_i = 1'b1;
    pwm_i = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (3) step();
    rst_i = 1'b0;
    apply_stimulus(1'b0, 3);
    pwm_burst(30, 30, 3);
    check_output("post_rst_duty", duty_o, 128);

    apply_stimulus(1'b0, 30);
    check_output("pending_reports", rep_q.size(), 0);
    check_output("pending_overruns", ovr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
